// File: rtl/memory_sized_port.sv
// memory_sized_port: byte-addressed little-endian memory with a combinational fetch port and a handshaked sized data port.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word data accesses.
module memory_sized_port #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
  parameter int MEM_BYTES = 4096,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] imem_addr_i,
  output logic [DWIDTH-1:0] imem_data_o,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);
  localparam int IW = $clog2(MEM_BYTES);
  localparam int EW = AWIDTH + 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic we_q, we_d, uns_q, uns_d;
  logic [1:0] size_q, size_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [7:0] main_memory [0:MEM_BYTES-1];
  logic [AWIDTH-1:0] f_off, c_off, c_addr;
  logic [3:0][7:0] f_bytes, c_bytes;
  logic f_ok, idle, c_we, c_uns, c_err, go_resp, wr_en;
  logic [1:0] c_size;
  logic [2:0] c_n;
  logic [3:0] c_be;
  logic [DWIDTH-1:0] c_wdata, c_load;
  always_comb begin
    f_off = imem_addr_i - BASE_ADDR;
    f_ok = (imem_addr_i >= BASE_ADDR) && ({1'b0, f_off} + EW'(4) <= EW'(MEM_BYTES));
    for (int k = 0; k < 4; k++) f_bytes[k] = main_memory[f_off[IW-1:0] + IW'(k)];
  end
  assign imem_data_o = f_ok ? f_bytes : '0;
  // While idle the live request drives the commit path; afterwards the latched copy does.
  assign idle = state_q == S_IDLE;
  always_comb begin
    c_addr = idle ? req_addr_i : addr_q;
    c_we = idle ? req_we_i : we_q;
    c_size = idle ? req_size_i : size_q;
    c_uns = idle ? req_unsigned_i : uns_q;
    c_wdata = idle ? req_wdata_i : wdata_q;
    c_off = c_addr - BASE_ADDR;
    c_n = c_size == 2'b00 ? 3'd1 : c_size == 2'b01 ? 3'd2 : 3'd4;
    c_be = c_size == 2'b00 ? 4'b0001 : c_size == 2'b01 ? 4'b0011 : 4'b1111;
    c_err = (c_size == 2'b11) || (c_addr < BASE_ADDR) || ({1'b0, c_off} + EW'(c_n) > EW'(MEM_BYTES));
`ifdef MEM_ALIGN_CHECK_EN
    c_err = c_err || (c_size == 2'b01 && c_addr[0]) || (c_size == 2'b10 && c_addr[1:0] != 2'b00);
`endif
    for (int k = 0; k < 4; k++) c_bytes[k] = main_memory[c_off[IW-1:0] + IW'(k)];
    c_load = c_size == 2'b00 ? {{24{~c_uns & c_bytes[0][7]}}, c_bytes[0]} :
             c_size == 2'b01 ? {{16{~c_uns & c_bytes[1][7]}}, c_bytes[1], c_bytes[0]} : c_bytes;
    go_resp = (idle && req_valid_i && LATENCY == 1) || (state_q == S_WAIT && cnt_q == 4'd1);
    wr_en = go_resp && c_we && !c_err && !rst;
  end
  always_comb begin
    state_d = idle ? (req_valid_i ? (LATENCY == 1 ? S_RESP : S_WAIT) : S_IDLE) :
              state_q == S_WAIT ? (cnt_q == 4'd1 ? S_RESP : S_WAIT) : S_IDLE;
    cnt_d = idle && req_valid_i ? 4'(LATENCY - 1) : state_q == S_WAIT ? cnt_q - 4'd1 : 4'd0;
    rsp_valid_d = go_resp;
    rsp_err_d = go_resp && c_err;
    rsp_rdata_d = (go_resp && !c_we && !c_err) ? c_load : '0;
    addr_d = c_addr;
    we_d = c_we;
    size_d = c_size;
    uns_d = c_uns;
    wdata_d = c_wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      size_q <= '0;
      uns_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q <= addr_d;
      we_q <= we_d;
      size_q <= size_d;
      uns_q <= uns_d;
      wdata_q <= wdata_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (wr_en && c_be[k]) main_memory[c_off[IW-1:0] + IW'(k)] <= c_wdata[8*k +: 8];
  end
  assign req_ready_o = idle && !rst;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o = rsp_err_q;
endmodule

// File: tb/tb_memory_sized_port.sv
// tb_memory_sized_port: directed checks of memory_sized_port at LATENCY 1 and 3.
module tb_memory_sized_port;
  localparam logic [31:0] B = 32'h01000000;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] imem_addr = B, req_addr = '0, req_wdata = '0;
  logic req_we = 1'b0, req_uns = 1'b0, v1 = 1'b0, v3 = 1'b0;
  logic [1:0] req_size = '0;
  logic [31:0] d1, d3, rd1, rd3, rd;
  logic rdy1, rdy3, rv1, rv3, re1, re3, er, seen;
  int checks = 0, fails = 0, lat;
  always #5 clk = ~clk;
  memory_sized_port #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .imem_addr_i(imem_addr), .imem_data_o(d1),
    .req_valid_i(v1), .req_ready_o(rdy1), .req_addr_i(req_addr), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv1), .rsp_rdata_o(rd1), .rsp_err_o(re1));
  memory_sized_port #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .imem_addr_i(imem_addr), .imem_data_o(d3),
    .req_valid_i(v3), .req_ready_o(rdy3), .req_addr_i(req_addr), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv3), .rsp_rdata_o(rd3), .rsp_err_o(re3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic s3, input logic we, input logic [1:0] sz, input logic un,
                      input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_we = we; req_size = sz; req_uns = un; req_addr = a; req_wdata = wd;
    if (s3) v3 = 1'b1; else v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; v3 = 1'b0;
    lat = 0; seen = 1'b0;
    while (!(s3 ? rv3 : rv1) && lat < 20) begin
      seen = seen | rdy3;
      @(negedge clk);
      lat++;
    end
    rd = s3 ? rd3 : rd1;
    er = s3 ? re3 : re1;
    chk("latency", 32'(lat), s3 ? 32'd2 : 32'd0);
    if (s3) chk("l3_ready_low", 32'(seen), 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy1), 32'd0);
    chk("rst_valid", 32'(rv1), 32'd0);
    chk("rst_rdata", rd1, 32'd0);
    chk("rst_err", 32'(re1), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy1), 32'd1);
    imem_addr = B + 4;
    xfer(0, 1, 2'b10, 0, B + 4, 32'hDEADBEEF);
    chk("st_w_rdata", rd, 32'd0);
    chk("st_w_err", 32'(er), 32'd0);
    chk("fetch_after_st", d1, 32'hDEADBEEF);
    xfer(0, 0, 2'b10, 0, B + 4, 32'h0);
    chk("ld_w", rd, 32'hDEADBEEF);
    chk("ld_w_err", 32'(er), 32'd0);
    xfer(0, 1, 2'b10, 0, B, 32'hAABBCCDD);
    xfer(0, 0, 2'b00, 0, B + 3, 32'h0);
    chk("ld_b_s", rd, 32'hFFFFFFAA);
    xfer(0, 0, 2'b00, 1, B + 3, 32'h0);
    chk("ld_b_u", rd, 32'h000000AA);
    xfer(0, 0, 2'b01, 0, B, 32'h0);
    chk("ld_h_s", rd, 32'hFFFFCCDD);
    xfer(0, 0, 2'b01, 1, B + 2, 32'h0);
    chk("ld_h_u", rd, 32'h0000AABB);
    xfer(0, 1, 2'b00, 0, B + 1, 32'hFFFFFF11);
    xfer(0, 0, 2'b10, 1, B, 32'h0);
    chk("st_b_merge", rd, 32'hAABB11DD);
    xfer(0, 1, 2'b10, 0, B + 4092, 32'h55667788);
    xfer(0, 0, 2'b10, 0, B + 4094, 32'h0);
    chk("oob_ld_err", 32'(er), 32'd1);
    chk("oob_ld_rdata", rd, 32'd0);
    xfer(0, 1, 2'b10, 0, B + 4094, 32'hFFFFFFFF);
    chk("oob_st_err", 32'(er), 32'd1);
    imem_addr = B + 4092;
    @(negedge clk);
    chk("oob_st_nowrite", d1, 32'h55667788);
    xfer(0, 0, 2'b00, 0, B + 4095, 32'h0);
    chk("last_byte", rd, 32'h00000055);
    chk("last_byte_err", 32'(er), 32'd0);
    xfer(0, 0, 2'b11, 0, B, 32'h0);
    chk("sz11_ld_err", 32'(er), 32'd1);
    chk("sz11_ld_rdata", rd, 32'd0);
    xfer(0, 1, 2'b11, 0, B, 32'h0);
    chk("sz11_st_err", 32'(er), 32'd1);
    xfer(0, 0, 2'b00, 0, B - 1, 32'h0);
    chk("below_base_err", 32'(er), 32'd1);
    imem_addr = B;
    @(negedge clk);
    chk("sz11_nowrite", d1, 32'hAABB11DD);
    imem_addr = B + 4093;
    @(negedge clk);
    chk("fetch_oob", d1, 32'd0);
    imem_addr = B - 4;
    @(negedge clk);
    chk("fetch_below", d1, 32'd0);
    xfer(0, 1, 2'b10, 0, B + 8, 32'h44332211);
    imem_addr = B + 5;
    @(negedge clk);
    chk("fetch_misalign", d1, 32'h11DEADBE);
    xfer(0, 0, 2'b10, 0, B + 5, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_w_err", 32'(er), 32'd1);
    chk("mis_w_rdata", rd, 32'd0);
    xfer(0, 0, 2'b01, 0, B + 3, 32'h0);
    chk("mis_h_err", 32'(er), 32'd1);
`else
    chk("mis_w_err", 32'(er), 32'd0);
    chk("mis_w_rdata", rd, 32'h11DEADBE);
    xfer(0, 0, 2'b01, 0, B + 3, 32'h0);
    chk("mis_h", rd, 32'hFFFFEFAA);
`endif
    xfer(1, 1, 2'b10, 0, B + 16, 32'h0);
    chk("l3_ready_in_resp", 32'(rdy3), 32'd0);
    @(negedge clk);
    chk("l3_ready_after", 32'(rdy3), 32'd1);
    xfer(1, 0, 2'b10, 0, B + 16, 32'h0);
    chk("l3_ld", rd, 32'd0);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_addr = B + 16; req_wdata = 32'hCAFEF00D; v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    chk("l3_in_wait", 32'(rdy3), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    seen = rv3;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | rv3;
    end
    chk("rst_wait_no_rsp", 32'(seen), 32'd0);
    imem_addr = B + 16;
    @(negedge clk);
    chk("rst_wait_no_write", d3, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
